// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector-side peers.
package seq_pkg;

  localparam int SEQ_PAT_W = 3;
  localparam logic [SEQ_PAT_W-1:0] SEQ_DEFAULT_PAT = 3'b101;

  // Transmitter states: waiting for a request, shifting a frame, idling between frames.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  // Gap counter width; kept at least one bit so GAP=0 builds still elaborate.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Request/serial-output bundle of the pattern transmitter.
//
// Handshake: there is no ready signal. A request is taken on a rising edge
// where start=1, abort=0, repeat_cnt!=0 and the block is idle (busy=0);
// pattern and repeat_cnt are captured on that same edge. Requests seen while
// busy are dropped, so a master holding start high gets exactly one
// transmission per idle window. abort=1 cancels on the next edge.
interface sequence_generator_if
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;
  seq_state_t       state;

  modport master (
    output start, abort, pattern, repeat_cnt,
    input  dout, dvalid, busy, done, state
  );

  modport slave (
    input  start, abort, pattern, repeat_cnt,
    output dout, dvalid, busy, done, state
  );
endinterface

// File: rtl/sequence_generator_shift_reg.sv
// Parallel-load, MSB-first parallel-in/serial-out shift register.
module seq_shift_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;

  // Load takes priority over shift; the vacated LSB fills with zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeat_cnt
// times, with GAP idle cycles between frames, then pulses done.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_generator_if.slave  bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam int GCW   = gap_cnt_w(GAP);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PAT_W - 1);
  localparam logic [GCW-1:0]   GAP_LAST = (GAP > 0) ? GCW'(GAP - 1) : '0;

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic             done_q, done_d;
  logic             sr_load, sr_shift;
  logic [PAT_W-1:0] sr_din;
  logic             sr_msb;

  // Next-state and counter control; the shift register is reloaded for the
  // following frame as soon as the current one ends, so the gap needs no load.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    frames_d  = frames_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = pattern_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort && (bus.repeat_cnt != '0)) begin
          state_d   = ST_SEND;
          pattern_d = bus.pattern;
          frames_d  = bus.repeat_cnt;
          idx_d     = IDX_TOP;
          sr_load   = 1'b1;
          sr_din    = bus.pattern;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == '0) begin
          if (frames_q > CNT_W'(1)) begin
            frames_d = frames_q - CNT_W'(1);
            sr_load  = 1'b1;
            if (GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              idx_d = IDX_TOP;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d    = idx_q - IDX_W'(1);
          sr_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_SEND;
          idx_d   = IDX_TOP;
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      frames_q  <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      frames_q  <= frames_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
    end
  end

  seq_shift_reg #(.W(PAT_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  // Outputs depend only on flops, so they are glitch-free and clear with reset.
  assign bus.dout   = (state_q == ST_SEND) & sr_msb;
  assign bus.dvalid = (state_q == ST_SEND);
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: one instance with GAP=1 and one with GAP=0
// share stimulus; each is checked cycle by cycle against a frame-plan model.
module tb_sequence_generator;
  import seq_pkg::*;

  localparam int PW = SEQ_PAT_W;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sequence_generator_if #(.PAT_W(PW), .CNT_W(CW)) bus_g1 ();
  sequence_generator_if #(.PAT_W(PW), .CNT_W(CW)) bus_g0 ();

  sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(1)) dut_g1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_g1.slave)
  );

  sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(0)) dut_g0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_g0.slave)
  );

  // ---------------- scoreboard state ----------------
  // Expected per-cycle tuple {busy, dvalid, dout, done}.
  logic [3:0] exp_q1[$];
  logic [3:0] exp_q0[$];
  logic [3:0] exp1, exp0;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic          s_start, s_abort;
  logic [PW-1:0] s_pat;
  logic [CW-1:0] s_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic ab, input logic [PW-1:0] pat,
                       input logic [CW-1:0] cnt);
    s_start = st; s_abort = ab; s_pat = pat; s_cnt = cnt;
    bus_g1.start = st; bus_g1.abort = ab; bus_g1.pattern = pat; bus_g1.repeat_cnt = cnt;
    bus_g0.start = st; bus_g0.abort = ab; bus_g0.pattern = pat; bus_g0.repeat_cnt = cnt;
  endtask

  // ---------------- reference model ----------------
  // A transmission is a list of output cycles: frames of pattern bits,
  // gap cycles between frames, then one done cycle.
  task automatic plan(input int gap, input logic [PW-1:0] pat, input logic [CW-1:0] cnt,
                      input bit which);
    logic [3:0] v;
    for (int f = 0; f < int'(cnt); f++) begin
      for (int b = PW - 1; b >= 0; b--) begin
        v = {2'b11, pat[b], 1'b0};
        if (which) exp_q1.push_back(v); else exp_q0.push_back(v);
      end
      if (f < int'(cnt) - 1) begin
        for (int k = 0; k < gap; k++) begin
          if (which) exp_q1.push_back(4'b1000); else exp_q0.push_back(4'b1000);
        end
      end
    end
    if (which) exp_q1.push_back(4'b0001); else exp_q0.push_back(4'b0001);
  endtask

  // Idle means nothing left to emit; the done cycle itself counts as idle
  // for the following edge because its tuple has already been popped.
  task automatic model_edge();
    if (s_abort) begin
      exp_q1.delete();
      exp_q0.delete();
    end else if (s_start && (s_cnt != '0)) begin
      if (exp_q1.size() == 0) plan(1, s_pat, s_cnt, 1'b1);
      if (exp_q0.size() == 0) plan(0, s_pat, s_cnt, 1'b0);
    end
    exp1 = (exp_q1.size() != 0) ? exp_q1.pop_front() : 4'b0000;
    exp0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : 4'b0000;
  endtask

  task automatic check_outputs(input string tag1, input string tag0,
                               input logic [3:0] e1, input logic [3:0] e0);
    check(tag1, {28'd0, bus_g1.busy, bus_g1.dvalid, bus_g1.dout, bus_g1.done}, {28'd0, e1});
    check(tag0, {28'd0, bus_g0.busy, bus_g0.dvalid, bus_g0.dout, bus_g0.done}, {28'd0, e0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs("out_gap1", "out_gap0", exp1, exp0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, PW'($urandom_range(0, 7)), CW'($urandom_range(0, 15)));
      step();
    end
  endtask

  task automatic reset_mid();
    reset = 1'b0;
    #1;
    check_outputs("rst_async_gap1", "rst_async_gap0", 4'b0000, 4'b0000);
    exp_q1.delete();
    exp_q0.delete();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold_gap1", "rst_hold_gap0", 4'b0000, 4'b0000);
    reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b0, 1'b0, '0, '0);
    #2 reset = 1'b0;
    #1;
    check_outputs("reset_gap1", "reset_gap0", 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // basic frame
    drive(1'b1, 1'b0, 3'b101, 4'd1); step();
    idle(5);
    // repeat with gap
    drive(1'b1, 1'b0, 3'b101, 4'd2); step();
    idle(9);
    // continuous frames on the zero-gap instance
    drive(1'b1, 1'b0, 3'b110, 4'd3); step();
    idle(12);
    // zero repeat count is ignored
    drive(1'b1, 1'b0, 3'b111, 4'd0); step();
    idle(3);
    // start held high across a transmission and its done cycle
    drive(1'b1, 1'b0, 3'b011, 4'd2);
    for (int i = 0; i < 20; i++) step();
    idle(4);
    // start with abort in idle sends nothing
    drive(1'b1, 1'b1, 3'b101, 4'd3); step();
    idle(3);
    // abort during the second bit
    drive(1'b1, 1'b0, 3'b101, 4'd1); step();
    idle(1);
    drive(1'b0, 1'b1, 3'b101, 4'd1); step();
    idle(4);
    // abort during a gap
    drive(1'b1, 1'b0, 3'b100, 4'd2); step();
    idle(3);
    drive(1'b0, 1'b1, 3'b000, 4'd0); step();
    idle(3);
    // reset mid-frame, then a clean frame
    drive(1'b1, 1'b0, 3'b101, 4'd3); step();
    idle(1);
    reset_mid();
    idle(2);
    drive(1'b1, 1'b0, SEQ_DEFAULT_PAT, 4'd1); step();
    idle(5);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
            PW'($urandom_range(0, 7)), CW'($urandom_range(0, 6)));
      step();
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter, the transmit-side counterpart of the sequence detector. It accepts a parallel bit pattern and a repeat count on a start handshake. It then shifts the pattern out MSB-first on a single-bit serial line, one bit per clock, with optional idle gaps between frames. It drives detector stimulus in-system and feeds the serial `din` of any downstream detector.

## Interface
- `PAT_W`, default 3: pattern length in bits (≥2).
- `CNT_W`, default 4: repeat-count width.
- `GAP`, default 1: idle cycles inserted between consecutive frames (0 allowed).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request transmission; sampled only in IDLE.
- `abort` in 1: synchronous cancel; returns the block to IDLE.
- `pattern` in `PAT_W`: pattern to send, MSB first; latched on start acceptance.
- `repeat_cnt` in `CNT_W`: number of frames; latched on start acceptance.
- `dout` in-to-out 1 (output): serial data.
- `dvalid` out 1: high when `dout` carries a pattern bit.
- `busy` out 1: high from the cycle after acceptance through the last bit.
- `done` out 1: one-cycle pulse after the last bit of the last frame.

## Operation
- All outputs are registered. Reset (`reset`=0) immediately clears `dout`, `dvalid`, `busy` and `done` to 0, forces IDLE, and clears the latched pattern and counters.
- States:
  - IDLE: `busy`=0, `dvalid`=0, `dout`=0.
  - SEND: `dvalid`=1, `dout`=`pattern_q[idx]`.
  - GAP: `dvalid`=0, `dout`=0, `busy`=1.
- IDLE→SEND: on `start`=1 with `repeat_cnt`≠0 and `abort`=0. This latches `pattern_q`, sets `frames_left`=`repeat_cnt` and `idx`=`PAT_W`-1.
- `start` with `repeat_cnt`=0 is ignored: no state change, no `done`.
- SEND: `idx` decrements each cycle. At `idx`=0:
  - if `frames_left`>1 and `GAP`>0: go to GAP, decrement `frames_left`;
  - if `frames_left`>1 and `GAP`=0: reload `idx`, stay in SEND, decrement `frames_left`;
  - if `frames_left`=1: go to IDLE and pulse `done`.
- GAP: counts `GAP` cycles, then returns to SEND with `idx`=`PAT_W`-1.
- `start` is ignored while not in IDLE. The pattern and count cannot change mid-transmission.
- `abort`=1 in any state: go to IDLE at the next edge with all outputs 0 and no `done` pulse.
  - Simultaneous `start` and `abort` in IDLE: `abort` wins.
- Counters: `idx` is `$clog2(PAT_W)` bits, `frames_left` is `CNT_W` bits, the gap counter is `$clog2(GAP+1)` bits. Nothing wraps, because all reload values are bounded.

## Timing
- `start` is sampled at edge E0. The first pattern bit appears on `dout` with `dvalid`=1 in the cycle after E0 (latency 1).
- Frame duration: `PAT_W` cycles. Inter-frame gap: exactly `GAP` cycles.
- Total busy span: `repeat_cnt`·`PAT_W` + (`repeat_cnt`−1)·`GAP` cycles.
- `done` is high for exactly the cycle immediately after the last bit, with `busy`=0 in that same cycle.
- Back-to-back: a `start` sampled during the `done` cycle is accepted. The next frame's first bit follows one cycle later.
- Reset mid-frame: outputs drop to 0 asynchronously. After reset deasserts, the block idles until a new `start`.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum `seq_state_t` {IDLE, SEND, GAP};
  - default constants `SEQ_PAT_W`=3 and `SEQ_DEFAULT_PAT`=3'b101, shared with the detector and its bench.
- One natural sub-module: `seq_shift_reg`, a parallel-load, MSB-first PISO with load and shift enables. The FSM and counters stay in the top module.

## Test plan
- Basic frame: `pattern`=3'b101, `repeat_cnt`=1, `GAP`=1, start at E0 → `dout` 1,0,1 with `dvalid`=1 in cycles 1–3; `done`=1 and `busy`=0 in cycle 4.
- Repeat with gap: 101, `repeat_cnt`=2, `GAP`=1 → 101 in cycles 1–3, `dvalid`=0 in cycle 4, 101 in cycles 5–7, `done` in cycle 8. The detector fed from `dout` asserts twice.
- Zero gap and zero count:
  - `GAP`=0, 3'b110, `repeat_cnt`=3 → continuous 110110110 with no `dvalid` drop.
  - `repeat_cnt`=0 → no `busy`, no `done`.
- Handshake corners:
  - `start` held high through the transmission → only one transmission is accepted, until the `done` cycle.
  - `start` and `abort` together in IDLE → nothing is sent.
- Abort and reset:
  - `abort` at cycle 2 of 101 → IDLE at cycle 3, outputs 0, no `done`.
  - `reset`=0 asserted mid-frame between edges → all outputs 0 immediately.
  - After release plus a new `start` → clean 101.
- Randomized pattern and count against a reference model: `dout` bit sequence and `done` timing match the cycle formula exactly.
